// File: rtl/iigs_kbd_pkg.sv
// Shared scancodes, $C025 bit positions, event record and scancode->ASCII base tables
// for the Apple IIgs keyboard decoder.
package iigs_kbd_pkg;

    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_ALT    = 8'h11;
    localparam logic [7:0] SC_LGUI   = 8'h1F;
    localparam logic [7:0] SC_CAPS   = 8'h58;
    localparam logic [7:0] SC_F12    = 8'h07;

    localparam int MOD_SHIFT   = 0;
    localparam int MOD_CTRL    = 1;
    localparam int MOD_CAPS    = 2;
    localparam int MOD_KEYPAD  = 4;
    localparam int MOD_CHANGED = 5;
    localparam int MOD_OPTION  = 6;
    localparam int MOD_OAPPLE  = 7;

    typedef struct packed {
        logic       press;
        logic       ext;
        logic [7:0] code;
    } kbd_evt_t;

    typedef struct packed {
        logic       valid;
        logic       letter;
        logic [6:0] lo;
        logic [6:0] hi;
    } kbd_map_t;

    function automatic kbd_map_t ltr(input logic [6:0] c);
        return '{valid: 1'b1, letter: 1'b1, lo: c, hi: c - 7'h20};
    endfunction

    function automatic kbd_map_t sym(input logic [6:0] lo, input logic [6:0] hi);
        return '{valid: 1'b1, letter: 1'b0, lo: lo, hi: hi};
    endfunction

    function automatic kbd_map_t map_plain(input logic [7:0] code);
        kbd_map_t m;
        case (code)
            8'h1C: m = ltr(7'h61);  8'h32: m = ltr(7'h62);  8'h21: m = ltr(7'h63);
            8'h23: m = ltr(7'h64);  8'h24: m = ltr(7'h65);  8'h2B: m = ltr(7'h66);
            8'h34: m = ltr(7'h67);  8'h33: m = ltr(7'h68);  8'h43: m = ltr(7'h69);
            8'h3B: m = ltr(7'h6A);  8'h42: m = ltr(7'h6B);  8'h4B: m = ltr(7'h6C);
            8'h3A: m = ltr(7'h6D);  8'h31: m = ltr(7'h6E);  8'h44: m = ltr(7'h6F);
            8'h4D: m = ltr(7'h70);  8'h15: m = ltr(7'h71);  8'h2D: m = ltr(7'h72);
            8'h1B: m = ltr(7'h73);  8'h2C: m = ltr(7'h74);  8'h3C: m = ltr(7'h75);
            8'h2A: m = ltr(7'h76);  8'h1D: m = ltr(7'h77);  8'h22: m = ltr(7'h78);
            8'h35: m = ltr(7'h79);  8'h1A: m = ltr(7'h7A);
            8'h16: m = sym(7'h31, 7'h21);  8'h1E: m = sym(7'h32, 7'h40);
            8'h26: m = sym(7'h33, 7'h23);  8'h25: m = sym(7'h34, 7'h24);
            8'h2E: m = sym(7'h35, 7'h25);  8'h36: m = sym(7'h36, 7'h5E);
            8'h3D: m = sym(7'h37, 7'h26);  8'h3E: m = sym(7'h38, 7'h2A);
            8'h46: m = sym(7'h39, 7'h28);  8'h45: m = sym(7'h30, 7'h29);
            8'h4E: m = sym(7'h2D, 7'h5F);  8'h55: m = sym(7'h3D, 7'h2B);
            8'h54: m = sym(7'h5B, 7'h7B);  8'h5B: m = sym(7'h5D, 7'h7D);
            8'h5D: m = sym(7'h5C, 7'h7C);  8'h4C: m = sym(7'h3B, 7'h3A);
            8'h52: m = sym(7'h27, 7'h22);  8'h0E: m = sym(7'h60, 7'h7E);
            8'h41: m = sym(7'h2C, 7'h3C);  8'h49: m = sym(7'h2E, 7'h3E);
            8'h4A: m = sym(7'h2F, 7'h3F);
            8'h5A: m = sym(7'h0D, 7'h0D);  8'h76: m = sym(7'h1B, 7'h1B);
            8'h66: m = sym(7'h7F, 7'h7F);  8'h0D: m = sym(7'h09, 7'h09);
            8'h29: m = sym(7'h20, 7'h20);
            // numeric keypad ignores shift
            8'h70: m = sym(7'h30, 7'h30);  8'h69: m = sym(7'h31, 7'h31);
            8'h72: m = sym(7'h32, 7'h32);  8'h7A: m = sym(7'h33, 7'h33);
            8'h6B: m = sym(7'h34, 7'h34);  8'h73: m = sym(7'h35, 7'h35);
            8'h74: m = sym(7'h36, 7'h36);  8'h6C: m = sym(7'h37, 7'h37);
            8'h75: m = sym(7'h38, 7'h38);  8'h7D: m = sym(7'h39, 7'h39);
            8'h71: m = sym(7'h2E, 7'h2E);  8'h7C: m = sym(7'h2A, 7'h2A);
            8'h7B: m = sym(7'h2D, 7'h2D);  8'h79: m = sym(7'h2B, 7'h2B);
            default: m = '0;
        endcase
        return m;
    endfunction

    function automatic kbd_map_t map_ext(input logic [7:0] code);
        kbd_map_t m;
        case (code)
            8'h6B:   m = sym(7'h08, 7'h08);
            8'h74:   m = sym(7'h15, 7'h15);
            8'h75:   m = sym(7'h0B, 7'h0B);
            8'h72:   m = sym(7'h0A, 7'h0A);
            default: m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/iigs_kbd_xlate.sv
// Combinational PS/2 set-2 scancode to IIgs ASCII translation with shift/caps/ctrl
// folding; the parent registers the result.
module iigs_kbd_xlate
    import iigs_kbd_pkg::*;
(
    input  logic       ext_i,
    input  logic [7:0] code_i,
    input  logic       shift_i,
    input  logic       ctrl_i,
    input  logic       caps_i,
    output logic       valid_o,
    output logic [6:0] ascii_o,
    output logic       keypad_o
);

    kbd_map_t m;

    always_comb begin
        m       = ext_i ? map_ext(code_i) : map_plain(code_i);
        valid_o = m.valid;
        if (m.letter) begin
            ascii_o = (shift_i || caps_i) ? m.hi : m.lo;
            if (ctrl_i) begin
                ascii_o = m.lo & 7'h1F;
            end
        end else begin
            ascii_o = shift_i ? m.hi : m.lo;
        end
        keypad_o = !ext_i && (code_i[7:4] == 4'h7);
    end

endmodule

// File: rtl/iigs_kbd_decoder.sv
// hps_io ps2_key consumer producing the IIgs $C000/$C010/$C025 keyboard registers.
// Optional type-ahead FIFO enabled by defining IIGS_KBD_TYPEAHEAD_EN.
module iigs_kbd_decoder
    import iigs_kbd_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [10:0] ps2_key,
    input  logic        kbd_strobe_clr,
    output logic [7:0]  kbd_data,
    output logic        any_key_down,
    output logic [7:0]  kbd_mod,
    output logic        reset_req,
    output logic        kbd_overflow
);

    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two >= 2");
    end

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    function automatic logic [3:0] sat_dec(input logic [3:0] v);
        return (v == 4'h0) ? v : v - 4'd1;
    endfunction

    logic       tog_q, armed_q, evt;
    logic       vld_p0_q, vld_p1_q;
    kbd_evt_t   evt_p0_q;
    logic       press_p1_q, xvld_p1_q, kp_p1_q, rreq_p1_q;
    logic [6:0] ascii_p1_q;
    logic       xl_valid, xl_keypad;
    logic [6:0] xl_ascii;
    logic       shift_q, ctrl_q, opt_q, oa_q, caps_q, chg_q, kp_q, rreq_q;
    logic       shift_d, ctrl_d, opt_d, oa_d, caps_d, chg_d;
    logic [3:0] cnt_q, cnt_d;
    logic       strobe_q, strobe_d;
    logic [6:0] ascii_q, ascii_d;
    logic       commit;

    assign evt = armed_q && (ps2_key[10] != tog_q);

    // S0: event capture
    always_ff @(posedge clk_sys) begin
        evt_p0_q <= ps2_key[9:0];
    end

    iigs_kbd_xlate u_xlate (
        .ext_i    (evt_p0_q.ext),
        .code_i   (evt_p0_q.code),
        .shift_i  (shift_q),
        .ctrl_i   (ctrl_q),
        .caps_i   (caps_q),
        .valid_o  (xl_valid),
        .ascii_o  (xl_ascii),
        .keypad_o (xl_keypad)
    );

    // S1: translate and modifier update
    always_ff @(posedge clk_sys) begin
        press_p1_q <= evt_p0_q.press;
        xvld_p1_q  <= xl_valid;
        ascii_p1_q <= xl_ascii;
        kp_p1_q    <= xl_keypad;
        rreq_p1_q  <= evt_p0_q.press && !evt_p0_q.ext && (evt_p0_q.code == SC_F12) && ctrl_q;
    end

    always_comb begin
        shift_d = shift_q;
        ctrl_d  = ctrl_q;
        opt_d   = opt_q;
        oa_d    = oa_q;
        caps_d  = caps_q;
        chg_d   = chg_q;
        if (kbd_strobe_clr) begin
            chg_d = 1'b0;
        end
        if (vld_p0_q) begin
            if ((evt_p0_q.code == SC_LSHIFT) || (evt_p0_q.code == SC_RSHIFT)) shift_d = evt_p0_q.press;
            if (evt_p0_q.code == SC_CTRL) ctrl_d = evt_p0_q.press;
            if (!evt_p0_q.ext && (evt_p0_q.code == SC_ALT)) opt_d = evt_p0_q.press;
            if (evt_p0_q.ext && ((evt_p0_q.code == SC_ALT) || (evt_p0_q.code == SC_LGUI)))
                oa_d = evt_p0_q.press;
            if (!evt_p0_q.ext && (evt_p0_q.code == SC_CAPS) && evt_p0_q.press) caps_d = !caps_q;
        end
        // a set in the same cycle as a clear wins
        if ({shift_d, ctrl_d, opt_d, oa_d, caps_d} != {shift_q, ctrl_q, opt_q, oa_q, caps_q}) begin
            chg_d = 1'b1;
        end
    end

    // S2: commit
    assign commit = vld_p1_q && press_p1_q && xvld_p1_q && !rreq_p1_q;

    always_comb begin
        cnt_d = cnt_q;
        if (vld_p1_q && xvld_p1_q) begin
            cnt_d = press_p1_q ? sat_inc(cnt_q) : sat_dec(cnt_q);
        end
    end

`ifdef IIGS_KBD_TYPEAHEAD_EN
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [6:0]  fifo_mem [FIFO_DEPTH];
    logic [AW:0] wr_q, rd_q, wr_d, rd_d;
    logic        ovf_q, ovf_d;
    logic        empty, full, bypass, pop, push;

    always_comb begin
        empty  = (wr_q == rd_q);
        full   = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        // an empty queue keeps the 3-cycle latency by loading the register directly
        bypass = commit && empty && (!strobe_q || kbd_strobe_clr);
        pop    = !strobe_q && !empty;
        push   = commit && !bypass && (!full || pop);
        wr_d   = push ? wr_q + 1'b1 : wr_q;
        rd_d   = pop ? rd_q + 1'b1 : rd_q;
        ovf_d  = ovf_q || (commit && !bypass && !push);
        strobe_d = strobe_q;
        ascii_d  = ascii_q;
        if (kbd_strobe_clr) begin
            strobe_d = 1'b0;
        end
        if (pop) begin
            strobe_d = 1'b1;
            ascii_d  = fifo_mem[rd_q[AW-1:0]];
        end
        if (bypass) begin
            strobe_d = 1'b1;
            ascii_d  = ascii_p1_q;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (push) begin
            fifo_mem[wr_q[AW-1:0]] <= ascii_p1_q;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            ovf_q <= 1'b0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            ovf_q <= ovf_d;
        end
    end

    assign kbd_overflow = ovf_q;
`else
    always_comb begin
        strobe_d = strobe_q;
        ascii_d  = ascii_q;
        if (kbd_strobe_clr) begin
            strobe_d = 1'b0;
        end
        if (commit) begin
            strobe_d = 1'b1;
            ascii_d  = ascii_p1_q;
        end
    end

    assign kbd_overflow = 1'b0;
`endif

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            tog_q    <= 1'b0;
            armed_q  <= 1'b0;
            vld_p0_q <= 1'b0;
            vld_p1_q <= 1'b0;
            shift_q  <= 1'b0;
            ctrl_q   <= 1'b0;
            opt_q    <= 1'b0;
            oa_q     <= 1'b0;
            caps_q   <= 1'b0;
            chg_q    <= 1'b0;
            kp_q     <= 1'b0;
            rreq_q   <= 1'b0;
            cnt_q    <= 4'd0;
            strobe_q <= 1'b0;
            ascii_q  <= 7'd0;
        end else begin
            tog_q    <= ps2_key[10];
            armed_q  <= 1'b1;
            vld_p0_q <= evt;
            vld_p1_q <= vld_p0_q;
            shift_q  <= shift_d;
            ctrl_q   <= ctrl_d;
            opt_q    <= opt_d;
            oa_q     <= oa_d;
            caps_q   <= caps_d;
            chg_q    <= chg_d;
            if (commit) begin
                kp_q <= kp_p1_q;
            end
            rreq_q   <= vld_p1_q && rreq_p1_q;
            cnt_q    <= cnt_d;
            strobe_q <= strobe_d;
            ascii_q  <= ascii_d;
        end
    end

    always_comb begin
        kbd_mod              = 8'h00;
        kbd_mod[MOD_SHIFT]   = shift_q;
        kbd_mod[MOD_CTRL]    = ctrl_q;
        kbd_mod[MOD_CAPS]    = caps_q;
        kbd_mod[MOD_KEYPAD]  = kp_q;
        kbd_mod[MOD_CHANGED] = chg_q;
        kbd_mod[MOD_OPTION]  = opt_q;
        kbd_mod[MOD_OAPPLE]  = oa_q;
    end

    assign kbd_data     = {strobe_q, ascii_q};
    assign any_key_down = (cnt_q != 4'd0);
    assign reset_req    = rreq_q;

endmodule

// File: tb/tb_iigs_kbd_decoder.sv
// Directed-vector bench for iigs_kbd_decoder; type-ahead vectors run when
// IIGS_KBD_TYPEAHEAD_EN is defined.
module tb_iigs_kbd_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] ps2_key;
    logic        strobe_clr;
    logic [7:0]  kbd_data;
    logic        any_key_down;
    logic [7:0]  kbd_mod;
    logic        reset_req;
    logic        kbd_overflow;

    int n_vec = 0;
    int n_bad = 0;

    iigs_kbd_decoder #(.FIFO_DEPTH(8)) dut (
        .clk_sys        (clk),
        .reset          (rst),
        .ps2_key        (ps2_key),
        .kbd_strobe_clr (strobe_clr),
        .kbd_data       (kbd_data),
        .any_key_down   (any_key_down),
        .kbd_mod        (kbd_mod),
        .reset_req      (reset_req),
        .kbd_overflow   (kbd_overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete (n_vec=%0d)", n_vec);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // toggle-coded event; returns #1 after the third edge, where the commit is visible
    task automatic ev(input logic p, input logic e, input logic [7:0] c);
        @(posedge clk);
        #1;
        ps2_key = {~ps2_key[10], p, e, c};
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic clr();
        @(posedge clk);
        #1 strobe_clr = 1'b1;
        @(posedge clk);
        #1 strobe_clr = 1'b0;
    endtask

`ifdef IIGS_KBD_TYPEAHEAD_EN
    logic [7:0] fifo_codes [10] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B};
    logic [7:0] fifo_exp   [8]  = '{8'hE2, 8'hE3, 8'hE4, 8'hE5, 8'hE6, 8'hE7, 8'hE8, 8'hE9};
`endif

    initial begin
        rst        = 1'b1;
        strobe_clr = 1'b0;
        ps2_key    = 11'h400;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data", kbd_data, 8'h00);
        chk("rst_mod", kbd_mod, 8'h00);
        chk("rst_akd", {7'd0, any_key_down}, 8'h00);
        chk("rst_rreq", {7'd0, reset_req}, 8'h00);
        chk("rst_ovf", {7'd0, kbd_overflow}, 8'h00);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("arm_noevt", kbd_data, 8'h00);

        // plain letter, then strobe clear
        ev(1'b1, 1'b0, 8'h1C);
        chk("t1_a", kbd_data, 8'hE1);
        clr();
        chk("t1_clr", kbd_data, 8'h61);
        ev(1'b0, 1'b0, 8'h1C);
        chk("t1_rel", kbd_data, 8'h61);

`ifdef IIGS_KBD_TYPEAHEAD_EN
        clr();
        for (int i = 0; i < 10; i++) ev(1'b1, 1'b0, fifo_codes[i]);
        chk("t6_first", kbd_data, 8'hE1);
        chk("t6_ovf", {7'd0, kbd_overflow}, 8'h01);
        for (int i = 0; i < 8; i++) begin
            clr();
            @(posedge clk);
            #1;
            chk("t6_pop", kbd_data, fifo_exp[i]);
        end
        clr();
        repeat (2) @(posedge clk);
        #1;
        chk("t6_drained", kbd_data, 8'h69);
        chk("t6_ovf_sticky", {7'd0, kbd_overflow}, 8'h01);
`else
        // shift
        ev(1'b1, 1'b0, 8'h12);
        chk("t2_shift_on", kbd_mod, 8'h21);
        ev(1'b1, 1'b0, 8'h1C);
        chk("t2_A", kbd_data, 8'hC1);
        ev(1'b1, 1'b0, 8'h16);
        chk("t2_bang", kbd_data, 8'hA1);
        ev(1'b0, 1'b0, 8'h16);
        ev(1'b0, 1'b0, 8'h1C);
        ev(1'b0, 1'b0, 8'h12);
        chk("t2_shift_off", kbd_mod, 8'h20);
        clr();
        chk("t2_chg_clr", kbd_mod, 8'h00);
        chk("t2_data_clr", kbd_data, 8'h21);

        // ctrl, Ctrl+F12, ctrl letter
        ev(1'b1, 1'b0, 8'h14);
        chk("t3_ctrl_on", kbd_mod, 8'h22);
        clr();
        chk("t3_ctrl_clr", kbd_mod, 8'h02);
        ev(1'b1, 1'b0, 8'h07);
        chk("t3_rreq_hi", {7'd0, reset_req}, 8'h01);
        chk("t3_no_strobe", kbd_data, 8'h21);
        @(posedge clk);
        #1;
        chk("t3_rreq_lo", {7'd0, reset_req}, 8'h00);
        ev(1'b0, 1'b0, 8'h07);
        ev(1'b1, 1'b0, 8'h1C);
        chk("t3_ctrl_a", kbd_data, 8'h81);
        ev(1'b0, 1'b0, 8'h1C);
        ev(1'b0, 1'b0, 8'h14);
        chk("t3_ctrl_off", kbd_mod, 8'h20);
        clr();

        // held count
        ev(1'b1, 1'b0, 8'h1C);
        ev(1'b1, 1'b0, 8'h32);
        chk("t4_two", {7'd0, any_key_down}, 8'h01);
        ev(1'b0, 1'b0, 8'h1C);
        chk("t4_one", {7'd0, any_key_down}, 8'h01);
        ev(1'b0, 1'b0, 8'h32);
        chk("t4_zero", {7'd0, any_key_down}, 8'h00);
        ev(1'b0, 1'b0, 8'h32);
        chk("t4_floor", {7'd0, any_key_down}, 8'h00);
        ev(1'b1, 1'b0, 8'h1C);
        chk("t4_after_floor", {7'd0, any_key_down}, 8'h01);
        ev(1'b0, 1'b0, 8'h1C);
        for (int i = 0; i < 16; i++) ev(1'b1, 1'b0, 8'h1C);
        chk("t4_sat_held", {7'd0, any_key_down}, 8'h01);
        for (int i = 0; i < 14; i++) ev(1'b0, 1'b0, 8'h1C);
        chk("t4_sat_14rel", {7'd0, any_key_down}, 8'h01);
        ev(1'b0, 1'b0, 8'h1C);
        chk("t4_sat_15rel", {7'd0, any_key_down}, 8'h00);

        // commit coincident with strobe clear
        clr();
        chk("t5_clr", kbd_data, 8'h61);
        ev(1'b1, 1'b0, 8'h32);
        chk("t5_b", kbd_data, 8'hE2);
        @(posedge clk);
        #1;
        ps2_key = {~ps2_key[10], 1'b1, 1'b0, 8'h1C};
        repeat (2) @(posedge clk);
        #1 strobe_clr = 1'b1;
        @(posedge clk);
        #1 strobe_clr = 1'b0;
        chk("t5_commit_wins", kbd_data, 8'hE1);
        ev(1'b0, 1'b0, 8'h32);
        ev(1'b0, 1'b0, 8'h1C);

        // specials, extended, keypad
        ev(1'b1, 1'b0, 8'h5A);
        chk("sp_enter", kbd_data, 8'h8D);
        ev(1'b1, 1'b1, 8'h6B);
        chk("sp_left", kbd_data, 8'h88);
        ev(1'b1, 1'b0, 8'h70);
        chk("sp_kp0", kbd_data, 8'hB0);
        chk("sp_kp_flag", kbd_mod, 8'h10);
        ev(1'b1, 1'b0, 8'h1C);
        chk("sp_kp_flag_off", kbd_mod, 8'h00);

        // caps lock toggles on press only
        ev(1'b1, 1'b0, 8'h58);
        chk("caps_on", kbd_mod, 8'h24);
        ev(1'b0, 1'b0, 8'h58);
        chk("caps_rel", kbd_mod, 8'h24);
        ev(1'b1, 1'b0, 8'h1C);
        chk("caps_A", kbd_data, 8'hC1);
        ev(1'b1, 1'b0, 8'h58);
        chk("caps_off", kbd_mod, 8'h20);
        clr();
        chk("caps_clr", kbd_data, 8'h41);

        // option / open-apple, unmapped key
        ev(1'b1, 1'b0, 8'h11);
        chk("opt_on", kbd_mod, 8'h60);
        ev(1'b1, 1'b1, 8'h1F);
        chk("oa_on", kbd_mod, 8'hE0);
        ev(1'b1, 1'b1, 8'h5A);
        chk("unmapped", kbd_data, 8'h41);
        chk("no_ovf", {7'd0, kbd_overflow}, 8'h00);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
